lcm_arbiter: RTL and testbench

Shares one iterative least-common-multiple engine between two independent requesters. Each requester presents an operand pair with a level request. The block grants the engine round-robin, runs the repeated-addition LCM search, and returns the result on a one-cycle done pulse with an overflow flag. It sits between the lab's input-capture logic and the result display/register stage.

---
 rtl/lcm_arb_pkg.sv | 13 +
 rtl/lcm_arbiter_if.sv | 15 +
 rtl/lcm_iter_core.sv | 54 +++++
 rtl/lcm_arbiter.sv | 117 +++++++++++
 tb/tb_lcm_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/lcm_arb_pkg.sv
// rtl/lcm_arb_pkg.sv - shared types and constants for the LCM arbiter
package lcm_arb_pkg;
    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    typedef logic port_idx_t;
endpackage

// File: rtl/lcm_arbiter_if.sv
// rtl/lcm_arbiter_if.sv - per-requester operand/result handshake bundle
interface lcm_arbiter_if #(
    parameter int WIDTH = lcm_arb_pkg::DEF_WIDTH
);
    logic             req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ack;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             ovf;

    modport master (output req, a, b, input ack, done, res, ovf);
    modport slave  (input req, a, b, output ack, done, res, ovf);
endinterface

// File: rtl/lcm_iter_core.sv
// rtl/lcm_iter_core.sv - repeated-addition LCM datapath (cand/mx/mn and detection flags)
module lcm_iter_core
    import lcm_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             hit_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic [WIDTH-1:0] cand_o
);
    logic [WIDTH-1:0] mx_q, mx_d;
    logic [WIDTH-1:0] mn_q, mn_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH:0]   sum;

    assign sum    = {1'b0, cand_q} + {1'b0, mx_q};
    assign zero_o = (a_i == '0) || (b_i == '0);
    // mn is never zero while stepping; the guard only keeps the modulo defined
    assign hit_o  = (mn_q != '0) && ((cand_q % mn_q) == '0);
    assign ovf_o  = sum[WIDTH];
    assign cand_o = cand_q;

    always_comb begin
        mx_d   = mx_q;
        mn_d   = mn_q;
        cand_d = cand_q;
        if (load_i) begin
            mx_d   = (a_i >= b_i) ? a_i : b_i;
            mn_d   = (a_i >= b_i) ? b_i : a_i;
            cand_d = (a_i >= b_i) ? a_i : b_i;
        end else if (step_i) begin
            cand_d = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mx_q   <= '0;
            mn_q   <= '0;
            cand_q <= '0;
        end else begin
            mx_q   <= mx_d;
            mn_q   <= mn_d;
            cand_q <= cand_d;
        end
    end
endmodule

// File: rtl/lcm_arbiter.sv
// rtl/lcm_arbiter.sv - round-robin sharing of one iterative LCM engine between two requesters
module lcm_arbiter
    import lcm_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    lcm_arbiter_if.slave port0,
    lcm_arbiter_if.slave port1,
    output logic        busy
);
    state_e           state_q, state_d;
    port_idx_t        owner_q, owner_d;
    port_idx_t        last_q, last_d;
    logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
    logic             ovf0_q, ovf0_d, ovf1_q, ovf1_d;

    logic             load, step, hit, ovf, zero;
    logic [WIDTH-1:0] cand, op_a, op_b;

    assign op_a = owner_q ? port1.a : port0.a;
    assign op_b = owner_q ? port1.b : port0.b;

    lcm_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .a_i    (op_a),
        .b_i    (op_b),
        .hit_o  (hit),
        .ovf_o  (ovf),
        .zero_o (zero),
        .cand_o (cand)
    );

    // Results land in the owner's registers on entry to DONE so they are valid with the done pulse
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        ovf0_d  = ovf0_q;
        ovf1_d  = ovf1_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (port0.req || port1.req) begin
                    state_d = LOAD;
                    if (port0.req && port1.req) owner_d = ~last_q;
                    else                        owner_d = port1.req;
                end
            end
            LOAD: begin
                load = 1'b1;
                if (zero) begin
                    state_d = DONE;
                    if (owner_q) begin res1_d = '0; ovf1_d = 1'b0; end
                    else         begin res0_d = '0; ovf0_d = 1'b0; end
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (hit) begin
                    state_d = DONE;
                    if (owner_q) begin res1_d = cand; ovf1_d = 1'b0; end
                    else         begin res0_d = cand; ovf0_d = 1'b0; end
                end else if (ovf) begin
                    state_d = DONE;
                    if (owner_q) begin res1_d = '0; ovf1_d = 1'b1; end
                    else         begin res0_d = '0; ovf0_d = 1'b1; end
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            res0_q  <= '0;
            res1_q  <= '0;
            ovf0_q  <= 1'b0;
            ovf1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            ovf0_q  <= ovf0_d;
            ovf1_q  <= ovf1_d;
        end
    end

    assign port0.ack  = (state_q == LOAD) && !owner_q;
    assign port1.ack  = (state_q == LOAD) &&  owner_q;
    assign port0.done = (state_q == DONE) && !owner_q;
    assign port1.done = (state_q == DONE) &&  owner_q;
    assign port0.res  = res0_q;
    assign port1.res  = res1_q;
    assign port0.ovf  = ovf0_q;
    assign port1.ovf  = ovf1_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_lcm_arbiter.sv
// tb/tb_lcm_arbiter.sv - scoreboard bench for lcm_arbiter
module tb_lcm_arbiter;
    typedef struct {
        int          port;
        logic [31:0] res;
        logic        ovf;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   active = 1'b0;
    exp_t sb[$];
    logic [31:0] shadow_res [2];
    logic        shadow_ovf [2];

    lcm_arbiter_if #(.WIDTH(32)) if0 ();
    lcm_arbiter_if #(.WIDTH(32)) if1 ();

    lcm_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .port0 (if0),
        .port1 (if1),
        .busy  (busy)
    );

    logic [1:0]  ack_w, done_w, ovf_w;
    logic [31:0] res_w [2];
    logic [31:0] a_w [2];
    logic [31:0] b_w [2];
    assign ack_w  = {if1.ack, if0.ack};
    assign done_w = {if1.done, if0.done};
    assign ovf_w  = {if1.ovf, if0.ovf};
    assign res_w[0] = if0.res;
    assign res_w[1] = if1.res;
    assign a_w[0] = if0.a;
    assign a_w[1] = if1.a;
    assign b_w[0] = if0.b;
    assign b_w[1] = if1.b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o, output int k);
        logic [63:0] mx, mn, cand;
        r = '0; o = 1'b0; k = 0;
        if (a == 0 || b == 0) return;
        mx = (a > b) ? {32'd0, a} : {32'd0, b};
        mn = (a > b) ? {32'd0, b} : {32'd0, a};
        cand = mx;
        forever begin
            k++;
            if (cand % mn == 0) begin r = cand[31:0]; return; end
            if (cand + mx > 64'hFFFF_FFFF) begin o = 1'b1; return; end
            cand = cand + mx;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            active = 1'b0;
            shadow_res[0] = '0; shadow_res[1] = '0;
            shadow_ovf[0] = 1'b0; shadow_ovf[1] = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (ack_w[p]) begin
                    exp_t e;
                    int k;
                    model(a_w[p], b_w[p], e.res, e.ovf, k);
                    e.port = p;
                    e.due  = cyc + 1 + k;
                    sb.push_back(e);
                    active = 1'b1;
                end
            end
            chk("busy", busy, active);
            for (int p = 0; p < 2; p++) begin
                if (done_w[p]) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done", done_w[p], 1'b0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("done_port", p, e.port);
                        chk("res", res_w[p], e.res);
                        chk("ovf", ovf_w[p], e.ovf);
                        chk("done_cycle", cyc, e.due);
                        shadow_res[p] = e.res;
                        shadow_ovf[p] = e.ovf;
                    end
                    chk("other_res", res_w[1-p], shadow_res[1-p]);
                    chk("other_ovf", ovf_w[1-p], shadow_ovf[1-p]);
                    active = 1'b0;
                end
            end
        end
    end

    task automatic set_req(input int p, input logic v);
        if (p == 0) if0.req = v; else if1.req = v;
    endtask

    task automatic start(input int p, input logic [31:0] a, input logic [31:0] b, output int t);
        @(posedge clk); #1;
        if (p == 0) begin if0.a = a; if0.b = b; end
        else        begin if1.a = a; if1.b = b; end
        set_req(p, 1'b1);
        t = cyc;
    endtask

    task automatic wait_sig(input int p, input bit is_done, output int c);
        bit ok = 1'b0;
        c = -1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if ((!is_done && ack_w[p]) || (is_done && done_w[p])) begin
                ok = 1'b1;
                c = cyc;
            end
        end
        chk(is_done ? "done_timeout" : "ack_timeout", ok, 1'b1);
    endtask

    initial begin
        int t, t1, c;
        if0.req = 0; if0.a = 0; if0.b = 0;
        if1.req = 0; if1.a = 0; if1.b = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_res0", if0.res, 0);
        chk("rst_res1", if1.res, 0);
        chk("rst_ovf", ovf_w, 0);
        chk("rst_ack", ack_w, 0);
        chk("rst_done", done_w, 0);

        // tie right after reset: port 0 first
        @(posedge clk); #1;
        if0.a = 3; if0.b = 5; if1.a = 2; if1.b = 2;
        if0.req = 1; if1.req = 1; t = cyc;
        wait_sig(0, 0, c); chk("tie_ack0", c, t + 1); set_req(0, 0);
        wait_sig(1, 0, c); chk("tie_ack1", c, t + 7); set_req(1, 0);
        wait_sig(1, 1, c); chk("tie_done1", c, t + 9);

        // repeated tie: last owner is port 1, so port 0 again
        @(posedge clk); #1;
        if0.req = 1; if1.req = 1; t = cyc;
        wait_sig(0, 0, c); chk("tie2_ack0", c, t + 1); set_req(0, 0);
        wait_sig(1, 0, c); set_req(1, 0);
        wait_sig(1, 1, c);

        start(0, 4, 6, t);
        wait_sig(0, 0, c); chk("p0_ack", c, t + 1); set_req(0, 0);
        wait_sig(0, 1, c); chk("p0_done", c, t + 4);

        start(0, 0, 7, t);
        wait_sig(0, 0, c); set_req(0, 0);
        wait_sig(0, 1, c); chk("zero_done", c, t + 2);

        start(0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, t);
        wait_sig(0, 0, c); set_req(0, 0);
        wait_sig(0, 1, c); chk("ovf_done", c, t + 3);

        // abort a long job with reset
        start(0, 97, 89, t);
        wait_sig(0, 0, c); set_req(0, 0);
        while (cyc < t + 10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_cycle", cyc, t + 11);
        chk("abort_busy", busy, 0);
        chk("abort_res0", if0.res, 0);
        chk("abort_ovf0", if0.ovf, 0);
        chk("abort_done0", if0.done, 0);
        chk("abort_ack0", if0.ack, 0);
        repeat (5) @(negedge clk);

        start(0, 1, 1, t);
        wait_sig(0, 0, c); set_req(0, 0);
        wait_sig(0, 1, c); chk("one_done", c, t + 3);

        // port 1 holds req across its own done
        start(1, 6, 4, t);
        wait_sig(1, 0, c); chk("hold_ack1", c, t + 1);
        wait_sig(1, 1, t1); chk("hold_done1", t1, t + 4);
        wait_sig(1, 0, c); chk("hold_ack1b", c, t1 + 2); set_req(1, 0);
        wait_sig(1, 1, c);
        chk("hold_res0", if0.res, 1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
